// File: rtl/primitive_scheduler.sv
// Opcode FIFO plus sequencer that splits shapes into line/arc primitives for the rasterizers.
// Waits on the selected rasterizer's done before each next primitive; op_ready drops when the FIFO is full.
module primitive_scheduler #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         op_valid,
  input  logic [95:0]                  op_data,
  output logic                         op_ready,
  input  logic                         line_done,
  input  logic                         arc_done,
  output logic                         prim_start,
  output logic                         prim_sel,
  output logic [37:0]                  locations,
  output logic [15:0]                  color,
  output logic                         shape_done,
  output logic                         bad_opcode,
  output logic                         busy,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int OP_W  = 77;
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(FIFO_DEPTH);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] DECODE = 2'd1;
  localparam logic [1:0] ISSUE  = 2'd2;
  localparam logic [1:0] WAIT   = 2'd3;

  localparam logic [3:0] SH_LINE   = 4'd0;
  localparam logic [3:0] SH_TRI    = 4'd1;
  localparam logic [3:0] SH_CIRCLE = 4'd2;

  // Only shape/color/loc1..loc3 are stored; fill and the spare field are dropped at the FIFO input.
  logic [OP_W-1:0]  mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             full;
  logic             push;
  logic             pop;

  logic [1:0]       state;
  logic [1:0]       seg;
  logic [OP_W-1:0]  op_reg;
  logic [3:0]       shape;
  logic             done;
  logic             last_seg;
  logic             unused_bits;

  assign full        = (count == FULL_CNT);
  assign op_ready    = ~full;
  assign push        = op_valid & ~full;
  assign pop         = (state == IDLE) && (count != '0);
  assign fifo_count  = count;
  assign busy        = (state != IDLE) || (count != '0);
  assign unused_bits = ^op_data[18:0];

  assign shape    = op_reg[76:73];
  assign done     = prim_sel ? arc_done : line_done;
  assign last_seg = (shape != SH_TRI) || (seg == 2'd2);

  function automatic logic [37:0] seg_locs(input logic [OP_W-1:0] op, input logic [1:0] s);
    logic [18:0] l1;
    logic [18:0] l2;
    logic [18:0] l3;
    l1 = op[56:38];
    l2 = op[37:19];
    l3 = op[18:0];
    seg_locs = {l1, l2};
    if (op[76:73] == SH_TRI) begin
      if (s == 2'd1)      seg_locs = {l1, l3};
      else if (s == 2'd2) seg_locs = {l2, l3};
    end
  endfunction

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= op_data[95:19];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // A segment advance enters ISSUE with prim_start low and raises it one cycle later,
  // so the first primitive of a shape is the only one launched straight out of DECODE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      seg        <= '0;
      op_reg     <= '0;
      prim_start <= 1'b0;
      prim_sel   <= 1'b0;
      locations  <= '0;
      color      <= '0;
      shape_done <= 1'b0;
      bad_opcode <= 1'b0;
    end else begin
      prim_start <= 1'b0;
      shape_done <= 1'b0;
      bad_opcode <= 1'b0;
      case (state)
        IDLE: begin
          if (pop) begin
            op_reg <= mem[rd_ptr];
            state  <= DECODE;
          end
        end
        DECODE: begin
          seg <= '0;
          if (shape == SH_LINE || shape == SH_TRI || shape == SH_CIRCLE) begin
            color      <= op_reg[72:57];
            prim_sel   <= (shape == SH_CIRCLE);
            locations  <= seg_locs(op_reg, 2'd0);
            prim_start <= 1'b1;
            state      <= ISSUE;
          end else begin
            bad_opcode <= 1'b1;
            state      <= IDLE;
          end
        end
        ISSUE: begin
          if (prim_start) state <= WAIT;
          else            prim_start <= 1'b1;
        end
        WAIT: begin
          if (done) begin
            if (last_seg) begin
              shape_done <= 1'b1;
              state      <= IDLE;
            end else begin
              seg       <= seg + 2'd1;
              locations <= seg_locs(op_reg, seg + 2'd1);
              state     <= ISSUE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
